bus_arbiter: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 27 ++
 rtl/bus_arbiter.sv | 86 ++++++++
 tb/tb_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared constants, state encoding and helpers for the result-bus arbiter.
package bus_arb_pkg;

    localparam int NREQ            = 8;
    localparam int WIDTH           = 16;
    localparam int SEL_W           = 3;
    localparam int MAXHOLD_DEFAULT = 15;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT   = GRANT,
        ST_RELEASE = RELEASE
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after Ptr, wrapping.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NREQ-1:0]  Req,
    input  logic [SEL_W-1:0] Ptr,
    output logic [SEL_W-1:0] Idx,
    output logic             Any
);

    logic [SEL_W-1:0] j;

    // Ptr itself is scanned last, so the previous grantee has lowest priority.
    always_comb begin
        Idx = '0;
        Any = 1'b0;
        j   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = Ptr + SEL_W'(k + 1);
            if (!Any && Req[j]) begin
                Idx = j;
                Any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared result bus: one-hot grant, mux select,
// registered bus capture and a hold limit that preempts long owners.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAXHOLD = MAXHOLD_DEFAULT
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [NREQ-1:0]  Req,
    input  logic [WIDTH-1:0] Bus_in,
    output logic [SEL_W-1:0] Sel,
    output logic [NREQ-1:0]  Grant,
    output logic             Valid,
    output logic [WIDTH-1:0] Bus_q,
    output logic             Preempt,
    output logic             Busy
);

    state_t           state, state_nx;
    logic [SEL_W-1:0] g, g_nx, ptr, ptr_nx, pick_idx;
    logic [3:0]       hold, hold_nx;
    logic [WIDTH-1:0] bus_nx;
    logic             pre_nx, pick_any;

    rr_pick u_pick (
        .Req (Req),
        .Ptr (ptr),
        .Idx (pick_idx),
        .Any (pick_any)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            g       <= '0;
            ptr     <= '1;
            hold    <= '0;
            Bus_q   <= '0;
            Preempt <= 1'b0;
        end else begin
            state   <= state_nx;
            g       <= g_nx;
            ptr     <= ptr_nx;
            hold    <= hold_nx;
            Bus_q   <= bus_nx;
            Preempt <= pre_nx;
        end
    end

    always_comb begin
        state_nx = state;
        g_nx     = g;
        ptr_nx   = ptr;
        hold_nx  = hold;
        bus_nx   = Bus_q;
        pre_nx   = 1'b0;
        case (state)
            ST_GRANT: begin
                bus_nx  = Bus_in;
                hold_nx = hold + 4'd1;
                if (!Req[g] || hold == 4'(MAXHOLD - 1)) begin
                    state_nx = ST_RELEASE;
                    ptr_nx   = g;
                    // Only a forced end (owner still requesting) is a preemption.
                    pre_nx   = Req[g];
                end
            end
            default: begin
                // IDLE and RELEASE share the pick path; RELEASE sees the updated ptr.
                state_nx = ST_IDLE;
                if (pick_any) begin
                    state_nx = ST_GRANT;
                    g_nx     = pick_idx;
                    hold_nx  = '0;
                end
            end
        endcase
    end

    assign Sel   = g;
    assign Valid = (state == ST_GRANT);
    assign Busy  = (state != ST_IDLE);
    assign Grant = Valid ? onehot(g) : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: two arbiters (hold limits 2 and 15) share stimulus and
// are each compared every cycle against a behavioural round-robin model.
module tb_bus_arbiter;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  Req = '0;
    logic [15:0] Bus_in = '0;

    logic [2:0]  sel_o   [2];
    logic [7:0]  grant_o [2];
    logic        valid_o [2];
    logic [15:0] busq_o  [2];
    logic        pre_o   [2];
    logic        busy_o  [2];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    bus_arbiter #(.MAXHOLD(2)) dut_a (
        .CLK(CLK), .Reset_n(Reset_n), .Req(Req), .Bus_in(Bus_in),
        .Sel(sel_o[0]), .Grant(grant_o[0]), .Valid(valid_o[0]),
        .Bus_q(busq_o[0]), .Preempt(pre_o[0]), .Busy(busy_o[0]));

    bus_arbiter #(.MAXHOLD(15)) dut_b (
        .CLK(CLK), .Reset_n(Reset_n), .Req(Req), .Bus_in(Bus_in),
        .Sel(sel_o[1]), .Grant(grant_o[1]), .Valid(valid_o[1]),
        .Bus_q(busq_o[1]), .Preempt(pre_o[1]), .Busy(busy_o[1]));

    // Reference model: who owns the bus, for how long, and who went last.
    int          mh      [2] = '{2, 15};
    int          m_owner [2];
    int          m_last  [2];
    int          m_held  [2];
    int          m_sel   [2];
    bit          m_dead  [2];
    bit          m_pre   [2];
    logic [15:0] m_busq  [2];

    function automatic int rr_next(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++)
            if (r[(last + k) % 8]) return (last + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_last[d] = 7; m_held[d] = 0; m_sel[d] = 0;
            m_dead[d] = 0; m_pre[d] = 0; m_busq[d] = '0;
        end
    endtask

    task automatic model_step(input int d);
        int w;
        if (m_owner[d] >= 0) begin
            m_busq[d] = Bus_in;
            m_held[d]++;
            m_pre[d]  = 0;
            if (!Req[m_owner[d]] || m_held[d] >= mh[d]) begin
                m_pre[d]   = Req[m_owner[d]];
                m_last[d]  = m_owner[d];
                m_owner[d] = -1;
                m_dead[d]  = 1;
            end
        end else begin
            m_pre[d]  = 0;
            m_dead[d] = 0;
            w = rr_next(Req, m_last[d]);
            if (w >= 0) begin
                m_owner[d] = w; m_sel[d] = w; m_held[d] = 0;
            end
        end
    endtask

    function automatic logic [13:0] m_ctl(input int d);
        logic [7:0] gv;
        gv = (m_owner[d] >= 0) ? (8'd1 << m_owner[d]) : 8'd0;
        return {gv, 3'(m_sel[d]), m_owner[d] >= 0, (m_owner[d] >= 0) || m_dead[d], m_pre[d]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input int d);
        check($sformatf("ctl%0d", d),
              {grant_o[d], sel_o[d], valid_o[d], busy_o[d], pre_o[d]}, m_ctl(d));
        check($sformatf("busq%0d", d), busq_o[d], m_busq[d]);
    endtask

    task automatic tick();
        @(posedge CLK);
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        for (int d = 0; d < 2; d++) compare_model(d);
    endtask

    // Called just after an edge; reset is asserted and released between edges.
    task automatic do_reset();
        Req = '0;
        Reset_n = 1'b0;
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) compare_model(d);
        Reset_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid, busy, pre;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{8'h14, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{8'h04, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0};

        model_reset();
        #3;
        for (int d = 0; d < 2; d++) compare_model(d);
        Reset_n = 1'b1;

        // Vector table against the hold-15 arbiter.
        for (int i = 0; i < 11; i++) begin
            Req = tbl[i].req;
            tick();
            check($sformatf("tbl[%0d]", i),
                  {grant_o[1], sel_o[1], valid_o[1], busy_o[1], pre_o[1]},
                  {tbl[i].grant, tbl[i].sel, tbl[i].valid, tbl[i].busy, tbl[i].pre});
        end

        // All requesting, hold limit 2: 0..7,0 rotation, 2 grant + 1 preempted dead cycle.
        do_reset();
        Req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                check("rot_grant", grant_o[0], 8'd1 << (n % 8));
            end
            tick();
            check("rot_dead", {grant_o[0], pre_o[0]}, 9'h001);
        end

        // Last grantee 3 loses to 0 on the next pick.
        do_reset();
        Req = 8'h08; tick();
        Req = 8'h00; tick(); tick();
        Req = 8'h09; tick();
        check("ptr3_pick", grant_o[1], 8'h01);

        // Bus capture ramp over a 4-cycle grant, then hold.
        do_reset();
        Req = 8'h01; Bus_in = 16'hFFFF; tick();
        for (int i = 0; i < 4; i++) begin
            Bus_in = 16'(i);
            if (i == 3) Req = 8'h00;
            tick();
            check("ramp", busq_o[1], 32'(i));
        end
        Bus_in = 16'h1234; tick(); tick();
        check("ramp_hold", {busq_o[1], busy_o[1]}, {16'h0003, 1'b0});

        // Sole requester 5 with hold 15: preempt then immediate re-grant.
        do_reset();
        Req = 8'h20;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("solo_grant", grant_o[1], 8'h20);
        end
        tick();
        check("solo_pre", {grant_o[1], pre_o[1]}, 9'h001);
        tick();
        check("solo_regrant", {grant_o[1], pre_o[1]}, 9'h040);

        // Asynchronous reset mid-grant.
        do_reset();
        Req = 8'hF8; Bus_in = 16'hBEEF;
        tick(); tick(); tick();
        #3;
        Reset_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++)
            check("async_rst", {grant_o[d], valid_o[d], busq_o[d]}, 25'h0);
        #1;
        Reset_n = 1'b1;
        Req = 8'hFF;
        tick();
        check("rst_prio", {grant_o[0], grant_o[1]}, 16'h0101);

        // Randomised traffic, model-checked every cycle.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) Req = 8'($urandom) & 8'($urandom);
            Bus_in = 16'($urandom);
            if ($urandom_range(249) == 0) do_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
